// File: rtl/xain_audio_i2s_mixer.sv
// xain_audio_i2s_mixer: mixes two signed 16-bit sound sources with fixed gains,
// applies volume attenuation and saturation, and serialises the mono sample as
// 16-bit I2S on both slots. Everything runs on clk.
// Optional post-saturation one-pole low-pass: define XAIN_AUDIO_LPF_EN.
module xain_audio_i2s_mixer #(
   parameter int          MCLK_DIV  = 4,
   parameter logic [7:0]  GAIN1     = 8'd128,
   parameter logic [7:0]  GAIN2     = 8'd128,
   parameter int          LPF_SHIFT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] snd1,
   input  logic [15:0] snd2,
   input  logic        mute,
   input  logic [2:0]  vol,
   output logic        i2s_sclk,
   output logic        i2s_lrck,
   output logic        i2s_dac,
   output logic [15:0] mix_out,
   output logic        clip,
   output logic        sample_strobe
);
   localparam logic [7:0]         DIV_TC = 8'(MCLK_DIV - 1);
   localparam logic signed [24:0] G1     = 25'({1'b0, GAIN1});
   localparam logic signed [24:0] G2     = 25'({1'b0, GAIN2});

   logic [7:0]         div_cnt_q, div_cnt_d;
   logic               sclk_q, sclk_d;
   logic [4:0]         bit_cnt_q, bit_cnt_d;
   logic               lrck_q, lrck_d;
   logic               dac_q, dac_d;
   logic signed [15:0] cap1_q, cap1_d, cap2_q, cap2_d;
   logic               cap_vld_q, cap_vld_d;
   logic signed [24:0] p_q, p_d;
   logic               p_vld_q, p_vld_d;
   logic signed [24:0] q_q, q_d;
   logic               q_vld_q, q_vld_d;
   logic [15:0]        mix_q, mix_d;
   logic               clip_q, clip_d;
   logic [15:0]        shift_q, shift_d;
   logic               strobe_q, strobe_d;

   logic               tc, fall;
   logic [4:0]         n;
   logic [3:0]         idx;
   logic               sat_hi, sat_lo, sat;
   logic [15:0]        res;

   // Divider terminal count, sclk falling edge and the bit slot it starts.
   assign tc   = (div_cnt_q == DIV_TC);
   assign fall = tc && sclk_q;
   assign n    = bit_cnt_q + 5'd1;
   // Slot n carries bit (16 - n) mod 16: MSB right after each lrck change.
   assign idx  = 4'd0 - n[3:0];

   assign sat_hi = (q_q > 25'sd32767);
   assign sat_lo = (q_q < -25'sd32768);
   assign sat    = sat_hi | sat_lo;
   assign res    = sat_hi ? 16'h7FFF : (sat_lo ? 16'h8000 : q_q[15:0]);

`ifdef XAIN_AUDIO_LPF_EN
   logic signed [15:0] x_q, x_d, y_q, y_d;
   logic               sat_q, sat_d;
   logic               x_vld_q, x_vld_d;
   logic signed [16:0] y_diff;
   logic [15:0]        y_next;

   assign y_diff = 17'(x_q) - 17'(y_q);
   assign y_next = 16'(17'(y_q) + (y_diff >>> LPF_SHIFT));
`else
   localparam int unused_lpf_shift = LPF_SHIFT;
`endif

   // Next-state: divider, I2S framing, capture and the mixing pipeline.
   always_comb begin
      div_cnt_d = tc ? 8'd0 : div_cnt_q + 8'd1;
      sclk_d    = tc ? ~sclk_q : sclk_q;
      bit_cnt_d = bit_cnt_q;
      lrck_d    = lrck_q;
      dac_d     = dac_q;
      cap1_d    = cap1_q;
      cap2_d    = cap2_q;
      cap_vld_d = 1'b0;
      p_d       = p_q;
      p_vld_d   = cap_vld_q;
      q_d       = q_q;
      q_vld_d   = p_vld_q;
      mix_d     = mix_q;
      clip_d    = clip_q;
      shift_d   = shift_q;
      strobe_d  = 1'b0;

      if (fall) begin
         bit_cnt_d = n;
         lrck_d    = n[4];
         dac_d     = shift_q[idx];
         if (n == 5'd0) begin
            cap1_d    = mute ? 16'sd0 : snd1;
            cap2_d    = mute ? 16'sd0 : snd2;
            cap_vld_d = 1'b1;
         end
      end

      if (cap_vld_q) p_d = 25'(cap1_q) * G1 + 25'(cap2_q) * G2;
      if (p_vld_q)   q_d = (p_q >>> 7) >>> vol;

`ifdef XAIN_AUDIO_LPF_EN
      x_d     = x_q;
      y_d     = y_q;
      sat_d   = sat_q;
      x_vld_d = q_vld_q;
      if (q_vld_q) begin
         x_d   = res;
         sat_d = sat;
      end
      if (x_vld_q) begin
         y_d      = y_next;
         mix_d    = y_next;
         shift_d  = y_next;
         clip_d   = sat_q;
         strobe_d = 1'b1;
      end
`else
      if (q_vld_q) begin
         mix_d    = res;
         shift_d  = res;
         clip_d   = sat;
         strobe_d = 1'b1;
      end
`endif
   end

   // State registers with synchronous reset; a reset mid-frame aborts it.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt_q <= '0;
         sclk_q    <= 1'b0;
         bit_cnt_q <= '0;
         lrck_q    <= 1'b0;
         dac_q     <= 1'b0;
         cap1_q    <= '0;
         cap2_q    <= '0;
         cap_vld_q <= 1'b0;
         p_q       <= '0;
         p_vld_q   <= 1'b0;
         q_q       <= '0;
         q_vld_q   <= 1'b0;
         mix_q     <= '0;
         clip_q    <= 1'b0;
         shift_q   <= '0;
         strobe_q  <= 1'b0;
`ifdef XAIN_AUDIO_LPF_EN
         x_q       <= '0;
         y_q       <= '0;
         sat_q     <= 1'b0;
         x_vld_q   <= 1'b0;
`endif
      end else begin
         div_cnt_q <= div_cnt_d;
         sclk_q    <= sclk_d;
         bit_cnt_q <= bit_cnt_d;
         lrck_q    <= lrck_d;
         dac_q     <= dac_d;
         cap1_q    <= cap1_d;
         cap2_q    <= cap2_d;
         cap_vld_q <= cap_vld_d;
         p_q       <= p_d;
         p_vld_q   <= p_vld_d;
         q_q       <= q_d;
         q_vld_q   <= q_vld_d;
         mix_q     <= mix_d;
         clip_q    <= clip_d;
         shift_q   <= shift_d;
         strobe_q  <= strobe_d;
`ifdef XAIN_AUDIO_LPF_EN
         x_q       <= x_d;
         y_q       <= y_d;
         sat_q     <= sat_d;
         x_vld_q   <= x_vld_d;
`endif
      end
   end

   assign i2s_sclk      = sclk_q;
   assign i2s_lrck      = lrck_q;
   assign i2s_dac       = dac_q;
   assign mix_out       = mix_q;
   assign clip          = clip_q;
   assign sample_strobe = strobe_q;

endmodule

// File: tb/tb_xain_audio_i2s_mixer.sv
// Testbench for xain_audio_i2s_mixer: randomized sources checked against an
// arithmetic model of mixing, attenuation, saturation (and the optional
// low-pass), with the serial I2S stream decoded and compared per frame.
module tb_xain_audio_i2s_mixer;
   localparam int         MDIV  = 4;
   localparam logic [7:0] GA1   = 8'd128;
   localparam logic [7:0] GA2   = 8'd128;
   localparam int         LPF_S = 2;
`ifdef XAIN_AUDIO_LPF_EN
   localparam int         LAT   = 4;
`else
   localparam int         LAT   = 3;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] snd1, snd2;
   logic        mute;
   logic [2:0]  vol;
   logic        i2s_sclk, i2s_lrck, i2s_dac, clip, sample_strobe;
   logic [15:0] mix_out;

   int n_checks = 0;
   int n_err    = 0;

   xain_audio_i2s_mixer #(
      .MCLK_DIV (MDIV),
      .GAIN1    (GA1),
      .GAIN2    (GA2),
      .LPF_SHIFT(LPF_S)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .snd1         (snd1),
      .snd2         (snd2),
      .mute         (mute),
      .vol          (vol),
      .i2s_sclk     (i2s_sclk),
      .i2s_lrck     (i2s_lrck),
      .i2s_dac      (i2s_dac),
      .mix_out      (mix_out),
      .clip         (clip),
      .sample_strobe(sample_strobe)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Input values as seen by the DUT at each rising edge.
   logic [15:0] sh_s1, sh_s2;
   logic        sh_mute, sh_rst;
   logic [2:0]  sh_vol;
   always @(posedge clk) begin
      sh_s1   <= snd1;
      sh_s2   <= snd2;
      sh_mute <= mute;
      sh_vol  <= vol;
      sh_rst  <= reset;
   end

   typedef struct {
      logic [15:0] mix;
      logic        clip;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] tx_exp;
   logic [15:0] word;
   int          n_m, gap, since, y_m;
   logic        prev_sclk, prev_stb;

   function automatic exp_t model_sample(input logic [15:0] a, input logic [15:0] b,
                                         input logic m, input logic [2:0] v);
      exp_t e;
      int   s1, s2, p, q, x;
      s1 = m ? 0 : int'($signed(a));
      s2 = m ? 0 : int'($signed(b));
      p  = s1 * int'(GA1) + s2 * int'(GA2);
      q  = (p >>> 7) >>> v;
      e.clip = (q > 32767) || (q < -32768);
      x  = (q > 32767) ? 32767 : ((q < -32768) ? -32768 : q);
`ifdef XAIN_AUDIO_LPF_EN
      y_m = y_m + ((x - y_m) >>> LPF_S);
      e.mix = 16'(y_m);
`else
      e.mix = 16'(x);
`endif
      return e;
   endfunction

   // Stream monitor: decodes sclk falls, checks framing, serial words and strobes.
   always @(negedge clk) begin
      exp_t e;
      if (sh_rst) begin
         exp_q.delete();
         tx_exp    = 16'h0;
         word      = 16'h0;
         n_m       = 0;
         gap       = 0;
         since     = 0;
         y_m       = 0;
         prev_sclk = 1'b0;
         prev_stb  = 1'b0;
      end else begin
         gap++;
         since++;
         if (sample_strobe) begin
            check_val("strobe_width", 32'(prev_stb), 32'd0);
            if (exp_q.size() == 0) begin
               check_val("strobe_unexpected", 32'(sample_strobe), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check_val("mix_out", 32'(mix_out), 32'(e.mix));
               check_val("clip", 32'(clip), 32'(e.clip));
               check_val("strobe_latency", 32'(since), 32'(LAT));
               tx_exp = e.mix;
            end
         end
         if (prev_sclk && !i2s_sclk) begin
            check_val("sclk_period", 32'(gap), 32'(2 * MDIV));
            gap  = 0;
            n_m  = (n_m + 1) % 32;
            check_val("lrck", 32'(i2s_lrck), 32'(n_m >= 16));
            word = {word[14:0], i2s_dac};
            if (n_m == 16) check_val("left_word", 32'(word), 32'(tx_exp));
            if (n_m == 0) begin
               check_val("right_word", 32'(word), 32'(tx_exp));
               exp_q.push_back(model_sample(sh_s1, sh_s2, sh_mute, sh_vol));
               since = 0;
            end
         end
         prev_sclk = i2s_sclk;
         prev_stb  = sample_strobe;
      end
   end

   task automatic wait_strobe();
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (sample_strobe) return;
      end
      check_val("strobe_timeout", 32'(sample_strobe), 32'd1);
   endtask

   task automatic apply(input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] v, input logic m);
      snd1 = a;
      snd2 = b;
      vol  = v;
      mute = m;
   endtask

   typedef struct {
      logic [15:0] a, b;
      logic [2:0]  v;
      logic        m;
      logic [15:0] mix;
      logic        clp;
   } dir_t;

   dir_t dir_tab[6] = '{
      '{16'h1000, 16'h0000, 3'd0, 1'b0, 16'h1000, 1'b0},
      '{16'h7000, 16'h7000, 3'd0, 1'b0, 16'h7FFF, 1'b1},
      '{16'h8000, 16'h8000, 3'd0, 1'b0, 16'h8000, 1'b1},
      '{16'h1000, 16'h0400, 3'd2, 1'b0, 16'h0500, 1'b0},
      '{16'hFFFD, 16'h0000, 3'd1, 1'b0, 16'hFFFE, 1'b0},
      '{16'h1234, 16'h0777, 3'd0, 1'b1, 16'h0000, 1'b0}
   };

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      apply(16'h0, 16'h0, 3'd0, 1'b0);
      repeat (5) @(negedge clk);
      reset = 1'b0;
      wait_strobe();

`ifdef XAIN_AUDIO_LPF_EN
      apply(16'h4000, 16'h0, 3'd0, 1'b0);
      wait_strobe();
      check_val("lpf_step1", 32'(mix_out), 32'h1000);
      wait_strobe();
      check_val("lpf_step2", 32'(mix_out), 32'h1C00);
      wait_strobe();
      check_val("lpf_step3", 32'(mix_out), 32'h2500);
`else
      foreach (dir_tab[i]) begin
         apply(dir_tab[i].a, dir_tab[i].b, dir_tab[i].v, dir_tab[i].m);
         wait_strobe();
         check_val("dir_mix", 32'(mix_out), 32'(dir_tab[i].mix));
         check_val("dir_clip", 32'(clip), 32'(dir_tab[i].clp));
      end
`endif

      for (int k = 0; k < 20; k++) begin
         apply(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
               ($urandom_range(0, 7) == 0));
         wait_strobe();
      end

      // Reset in the middle of a frame with a non-zero source pending.
      apply(16'h1000, 16'h0, 3'd0, 1'b0);
      repeat (60) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_val("rst_sclk", 32'(i2s_sclk), 32'd0);
      check_val("rst_lrck", 32'(i2s_lrck), 32'd0);
      check_val("rst_dac", 32'(i2s_dac), 32'd0);
      check_val("rst_mix", 32'(mix_out), 32'd0);
      check_val("rst_clip", 32'(clip), 32'd0);
      check_val("rst_strobe", 32'(sample_strobe), 32'd0);
      repeat (9) @(negedge clk);
      reset = 1'b0;
      wait_strobe();
      wait_strobe();

      for (int k = 0; k < 6; k++) begin
         apply(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 1'b0);
         wait_strobe();
      end
      repeat (300) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
